// File: rtl/lc3_alu_mc.sv
// Multi-cycle LC-3 ALU: single-cycle logic ops plus iterative shifts and a shift-add
// multiplier, with valid/ready handshakes on both sides and registered NZP codes.
module lc3_alu_mc #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_k,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             gate_alu,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       nzp
);

  // Counter is one bit wider than the shift amount so it can hold WIDTH for MUL.
  localparam int unsigned CW = SHW + 1;

  localparam logic [2:0] K_ADD  = 3'b000;
  localparam logic [2:0] K_AND  = 3'b001;
  localparam logic [2:0] K_NOT  = 3'b010;
  localparam logic [2:0] K_PASS = 3'b011;
  localparam logic [2:0] K_SHL  = 3'b100;
  localparam logic [2:0] K_SHR  = 3'b101;
  localparam logic [2:0] K_ASR  = 3'b110;
  localparam logic [2:0] K_MUL  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
  logic [2:0]       nzp_q, nzp_d;
  logic [WIDTH-1:0] step_res, mul_sum, imm_res, fin_res;
  logic             imm, accept;
  logic [SHW-1:0]   amt;

  function automatic logic [2:0] calc_nzp(input logic [WIDTH-1:0] r);
    if (r == '0)          return 3'b010;
    else if (r[WIDTH-1])  return 3'b100;
    else                  return 3'b001;
  endfunction

  assign in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign out_valid = (state_q == S_DONE);
  assign accept    = in_valid & in_ready;
  assign amt       = op_b[SHW-1:0];
  assign alu_out   = gate_alu ? res_q : '0;
  assign nzp       = nzp_q;

  // One iteration of the working operand: single-bit shift, or multiplier step.
  always_comb begin
    step_res = a_q << 1;
    mul_sum  = acc_q + (b_q[0] ? a_q : '0);
    case (k_q)
      K_SHR:   step_res = {1'b0, a_q[WIDTH-1:1]};
      K_ASR:   step_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: step_res = {a_q[WIDTH-2:0], 1'b0};
    endcase
    fin_res = (k_q == K_MUL) ? mul_sum : step_res;
  end

  // Next-state and datapath update; a new accept overrides the per-state defaults.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    nzp_d   = nzp_q;
    imm     = 1'b1;
    imm_res = op_a;

    case (state_q)
      S_BUSY: begin
        a_d   = step_res;
        b_d   = b_q >> 1;
        acc_d = mul_sum;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = fin_res;
          nzp_d   = calc_nzp(fin_res);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      S_IDLE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      k_d   = alu_k;
      a_d   = op_a;
      b_d   = op_b;
      acc_d = '0;
      case (alu_k)
        K_ADD:  imm_res = op_a + op_b;
        K_AND:  imm_res = op_a & op_b;
        K_NOT:  imm_res = ~op_a;
        K_PASS: imm_res = op_a;
        K_SHL, K_SHR, K_ASR: begin
          imm_res = op_a;
          imm     = (amt == '0);
          cnt_d   = CW'(amt);
        end
        K_MUL: begin
          imm   = 1'b0;
          cnt_d = CW'(WIDTH);
        end
        default: imm_res = op_a;
      endcase
      if (imm) begin
        state_d = S_DONE;
        res_d   = imm_res;
        nzp_d   = calc_nzp(imm_res);
      end else begin
        state_d = S_BUSY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= K_ADD;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      nzp_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      nzp_q   <= nzp_d;
    end
  end

endmodule

// File: doc/lc3_alu_mc.md
# lc3_alu_mc

Parametrised multi-cycle successor to the LC-3 datapath ALU. Single-cycle ADD/AND/NOT/PASS are extended with iterative shifts and a shift-add multiplier. Operands arrive through a valid/ready handshake and results leave through one, with registered NZP condition codes. The block drives the shared datapath bus through `gate_alu` and feeds the condition-code logic.

## Interface
- `WIDTH`, default 16: datapath width in bits; must be ≥ 4.
- `SHW`, default 4: number of low `op_b` bits used as the shift amount; must equal clog2(`WIDTH`).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `alu_k`  in  3  opcode, sampled on accept.
- `op_a`  in  `WIDTH`  operand A, sampled on accept.
- `op_b`  in  `WIDTH`  operand B, sampled on accept.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept an operation.
- `out_valid`  out  1  result and NZP are valid.
- `out_ready`  in  1  consumer takes the result.
- `gate_alu`  in  1  bus drive enable.
- `alu_out`  out  `WIDTH`  result, equal to `res_q` when `gate_alu`=1, otherwise 0.
- `nzp`  out  3  condition codes {N,Z,P} of the held result.

## Operation
- An operation is accepted on a rising edge where `in_valid` & `in_ready` are both high. Operands and opcode are captured at that edge.
- Opcodes:
  - 000 ADD: a+b mod 2^`WIDTH`.
  - 001 AND: a&b.
  - 010 NOT: ~a.
  - 011 PASS: a.
  - 100 SHL: shift a left by `op_b[SHW-1:0]`, zero fill.
  - 101 SHR: logical right shift, zero fill.
  - 110 ASR: arithmetic right shift, MSB fill.
  - 111 MUL: low `WIDTH` bits of a*b. Identical for signed and unsigned operands.
- FSM states:
  - IDLE → DONE on accept of opcodes 000-011, or of a shift with amount 0.
  - IDLE → BUSY on accept of a shift with amount > 0, or of MUL.
  - BUSY → DONE when the iteration counter reaches its last step.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → DONE or BUSY when `out_ready` and a new accept occur on the same edge; the next state follows the new opcode.
- Shifts move one bit position per BUSY cycle. The counter is loaded with the shift amount.
- MUL performs one shift-add step per BUSY cycle on bit i of `op_b`: acc += a<<i. It always takes exactly `WIDTH` steps, with no early termination on zero operands.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- `out_valid` = (state==DONE).
- `nzp` is computed from the final result when entering DONE:
  - N = MSB.
  - Z = result==0.
  - P = !N & !Z.
  - Exactly one bit is set at all times.
- `res_q` and `nzp` hold stable while `out_valid` & !`out_ready`. A full DONE state backpressures the input (`in_ready`=0).
- `gate_alu` affects only `alu_out`. It has no effect on the FSM or the handshake. `alu_out` is 0, never X, when not gated.
- An `alu_k` value sampled with X or Z bits is treated as PASS.

## Timing
- Reset values: state IDLE, `res_q`=0, `nzp`=3'b010, `out_valid`=0, `in_ready`=1, counter 0, `alu_out`=0.
- Reset mid-operation, in BUSY or DONE, discards the operation immediately and asynchronously. `in_ready`=1 is presented at the first clock after reset deasserts.
- Latency from accept edge T to `out_valid`=1:
  - opcodes 000-011: T+1.
  - shift by n: T+1+n (n=0 gives T+1).
  - MUL: T+1+`WIDTH`.
- Throughput: one single-cycle op per clock when `out_ready` is held high.
- `in_valid` asserted while `in_ready`=0 is ignored. The requester must hold its request.
- Inputs must be stable only at the accept edge.

## Test plan
- Reset, then ADD 0x7FFF + 0x0001 with `out_ready`=1: `out_valid` one cycle later, `alu_out`=0x8000, `nzp`=100. Follow with AND 0x00F0 & 0x0F0F: 0x0000, `nzp`=010.
- SHL 0x0001 by 15: `out_valid` 16 cycles after accept, result 0x8000. SHR 0x8000 by 4: 0x0800. ASR 0x8000 by 4: 0xF800. SHL by 0: result equals `op_a` after 1 cycle.
- MUL 0x0003 × 0xFFFF: `out_valid` exactly 17 cycles after accept, result 0xFFFD, `nzp`=100. `in_ready`=0 throughout BUSY.
- Backpressure: hold `out_ready`=0 for 5 cycles after a NOT of 0x00FF.
  - During the stall, result 0xFF00 and `nzp`=100 stay stable and `in_ready`=0.
  - Raise `out_ready` together with `in_valid` for PASS 0x1234: the new op is accepted on that same edge, and 0x1234 appears next cycle with `nzp`=001.
- With `gate_alu`=0, `alu_out`=0 while `out_valid`=1 and `nzp` holds its value. Raising `gate_alu` shows the result in the same cycle.
- Assert `rst` low mid-MUL at step 8: all outputs take reset values immediately. After release, `in_ready`=1 and no stale `out_valid` appears.
